// File: rtl/sys_bus_master_seq.sv
// FIFO-queued single-beat system-bus initiator: strobe 2 cycles after a push into an empty FIFO, response 1 cycle after ack.
// cmd_ready_o drops only when the FIFO is full; a response is held until rsp_ready_i. SYS_BUS_TIMEOUT_EN adds an ack timeout.
module sys_bus_master_seq #(
  parameter int FAW      = 3,
  parameter int TOUT_CYC = 64
) (
  input  logic        dac_clk_i,
  input  logic        dac_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_tout_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_wdata_o,
  output logic        sys_wen_o,
  output logic        sys_ren_o,
  input  logic [31:0] sys_rdata_i,
  input  logic        sys_err_i,
  input  logic        sys_ack_i,
  output logic        busy_o
);

  localparam int             DEPTH   = 1 << FAW;
  localparam logic [FAW:0]   DEPTH_C = (FAW + 1)'(DEPTH);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t           mem_q [DEPTH];
  logic [FAW-1:0] wptr_q, rptr_q;
  logic [FAW:0]   cnt_q, cnt_d;
  logic           push, pop;

  state_t         state_q, state_d;
  logic           we_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic           err_q;
  logic           ack_seen, tout_hit;

  assign cmd_ready_o = (cnt_q != DEPTH_C);
  assign push        = cmd_valid_i && cmd_ready_o;
  // Acks are only meaningful while waiting; strays elsewhere fall through.
  assign ack_seen    = (state_q == WAIT) && (sys_ack_i || sys_err_i);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (FAW + 1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (FAW + 1)'(1);
  end

  always_ff @(posedge dac_clk_i) begin
    if (push) mem_q[wptr_q] <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FAW'(1);
      if (pop)  rptr_q <= rptr_q + FAW'(1);
      cnt_q <= cnt_d;
    end
  end

  // FSM: state register
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q != '0) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (ack_seen || tout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pop         = 1'b0;
    sys_wen_o   = 1'b0;
    sys_ren_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE:    pop         = (cnt_q != '0);
      ISSUE:   begin
        sys_wen_o = we_q;
        sys_ren_o = !we_q;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop) {we_q, addr_q, wdata_q} <= mem_q[rptr_q];
      if (ack_seen) begin
        rdata_q <= we_q ? 32'h0 : sys_rdata_i;
        err_q   <= sys_err_i;
      end else if (tout_hit) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  assign sys_addr_o  = addr_q;
  assign sys_wdata_o = we_q ? wdata_q : 32'h0;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (cnt_q != '0) || (state_q != IDLE);

`ifdef SYS_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  logic          tout_q;

  // An ack on the expiry cycle wins, so expiry is gated by !ack_seen.
  assign tout_hit   = (state_q == WAIT) && !ack_seen && (tcnt_q == TW'(TOUT_CYC - 1));
  assign rsp_tout_o = tout_q;

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     tcnt_q <= '0;
      else if (state_q == WAIT) tcnt_q <= tcnt_q + TW'(1);
      if (ack_seen)             tout_q <= 1'b0;
      else if (tout_hit)        tout_q <= 1'b1;
    end
  end
`else
  assign tout_hit   = 1'b0;
  assign rsp_tout_o = 1'b0 & (TOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_sys_bus_master_seq.sv
// Directed bench for sys_bus_master_seq: vector table of single commands plus FIFO-fill, stray-ack and reset sequences.
module tb_sys_bus_master_seq;

  localparam int FAW   = 3;
  localparam int DEPTH = 1 << FAW;

  logic        dac_clk_i, dac_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_tout_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] sys_addr_o, sys_wdata_o, sys_rdata_i;
  logic        sys_wen_o, sys_ren_o, sys_err_i, sys_ack_i, busy_o;

  logic        slv_en, slv_ack, man_ack, man_err;
  logic [31:0] slv_rdata, man_rdata;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int both_hi = 0;

  assign sys_ack_i   = slv_en ? slv_ack : man_ack;
  assign sys_err_i   = slv_en ? 1'b0 : man_err;
  assign sys_rdata_i = slv_en ? slv_rdata : man_rdata;

  sys_bus_master_seq #(.FAW(FAW), .TOUT_CYC(8)) dut (
    .dac_clk_i(dac_clk_i), .dac_rst_i(dac_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_tout_o(rsp_tout_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_wen_o(sys_wen_o),
    .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i),
    .sys_ack_i(sys_ack_i), .busy_o(busy_o)
  );

  initial begin
    dac_clk_i = 1'b0;
    forever #5 dac_clk_i = ~dac_clk_i;
  end

  // Auto slave: acks one cycle after each strobe, rdata = captured addr ^ 0xA5A50000.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    pend = 1'b0; pend_addr = '0; slv_ack = 1'b0; slv_rdata = '0;
    forever begin
      @(posedge dac_clk_i); #1;
      slv_ack   = pend;
      slv_rdata = pend ? (pend_addr ^ 32'hA5A50000) : 32'h0;
      pend      = slv_en && (sys_ren_o || sys_wen_o);
      if (pend) begin
        pend_addr = sys_addr_o;
        strobes++;
      end
      if (sys_ren_o && sys_wen_o) both_hi++;
    end
  end

  task automatic tick();
    @(posedge dac_clk_i); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  // Push one command into an idle engine; slave answers dly cycles after the strobe.
  task automatic run_vec(input vec_t v);
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
    check("cmd_ready_idle", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    check("no_strobe_c1", sys_wen_o | sys_ren_o, 0);
    tick();
    check("wen_c2", sys_wen_o, v.we);
    check("ren_c2", sys_ren_o, !v.we);
    check("addr_c2", sys_addr_o, v.addr);
    check("wdata_c2", sys_wdata_o, v.we ? v.wdata : 32'h0);
    man_rdata = 32'hBAD0BAD0;
    for (int i = 1; i < v.dly; i++) begin
      tick();
      check("no_strobe_wait", sys_wen_o | sys_ren_o, 0);
      check("addr_held", sys_addr_o, v.addr);
      check("no_rsp_wait", rsp_valid_o, 0);
    end
    tick();
    man_ack = v.ack; man_err = v.err; man_rdata = v.rdata;
    check("addr_ack_cyc", sys_addr_o, v.addr);
    check("wdata_ack_cyc", sys_wdata_o, v.we ? v.wdata : 32'h0);
    tick();
    man_ack = 1'b0; man_err = 1'b0; man_rdata = 32'h77777777;
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_rdata", rsp_rdata_o, v.exp_rdata);
    check("rsp_err", rsp_err_o, v.exp_err);
    check("rsp_tout", rsp_tout_o, 0);
    tick();
    check("rsp_hold_valid", rsp_valid_o, 1);
    check("rsp_hold_rdata", rsp_rdata_o, v.exp_rdata);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_drop", rsp_valid_o, 0);
    check("idle_busy", busy_o, 0);
  endtask

  initial begin
    int n, k;
    vecs[0] = '{we: 1'b1, addr: 32'h40200004, wdata: 32'h12342000, dly: 1, ack: 1'b1, err: 1'b0,
                rdata: 32'hDEADBEEF, exp_rdata: 32'h0, exp_err: 1'b0};
    vecs[1] = '{we: 1'b0, addr: 32'h40210010, wdata: 32'hFFFF0000, dly: 3, ack: 1'b1, err: 1'b0,
                rdata: 32'h00001ABC, exp_rdata: 32'h00001ABC, exp_err: 1'b0};
    vecs[2] = '{we: 1'b0, addr: 32'h40210020, wdata: 32'h0, dly: 1, ack: 1'b1, err: 1'b1,
                rdata: 32'h55AA55AA, exp_rdata: 32'h55AA55AA, exp_err: 1'b1};
    vecs[3] = '{we: 1'b1, addr: 32'h40200008, wdata: 32'hCAFEF00D, dly: 2, ack: 1'b0, err: 1'b1,
                rdata: 32'h11111111, exp_rdata: 32'h0, exp_err: 1'b1};

    dac_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; slv_en = 1'b0; man_ack = 1'b0; man_err = 1'b0; man_rdata = '0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_strobes", {sys_wen_o, sys_ren_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", sys_addr_o, 0);
    check("rst_rsp_fields", {rsp_rdata_o, rsp_err_o, rsp_tout_o}, 0);
    dac_rst_i = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Stray acks in IDLE must not create a response.
    man_ack = 1'b1; man_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_no_rsp", rsp_valid_o, 0);
      check("stray_no_busy", busy_o, 0);
    end
    man_ack = 1'b0; man_err = 1'b0;
    tick();

    // Fill: engine takes one command then stalls in RESP, FIFO absorbs DEPTH more.
    slv_en = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0;
      cmd_addr_i = 32'h40210000 + 32'(n * 4); cmd_wdata_i = 32'h0;
      if (cmd_ready_o) n++;
      tick();
    end
    cmd_valid_i = 1'b0;
    check("fill_accepted", 32'(n), 32'(DEPTH + 1));
    check("fill_ready_low", cmd_ready_o, 0);
    check("fill_busy", busy_o, 1);
    rsp_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && k < DEPTH + 1; c++) begin
      if (rsp_valid_o) begin
        check("fifo_order_rdata", rsp_rdata_o, (32'h40210000 + 32'(k * 4)) ^ 32'hA5A50000);
        check("fifo_rsp_err", rsp_err_o, 0);
        k++;
      end
      tick();
    end
    rsp_ready_i = 1'b0;
    check("fifo_rsp_count", 32'(k), 32'(DEPTH + 1));
    tick(); tick();
    slv_en = 1'b0;
    check("fifo_strobe_count", 32'(strobes), 32'(DEPTH + 1));
    check("fifo_drained_ready", cmd_ready_o, 1);
    check("fifo_drained_busy", busy_o, 0);

`ifdef SYS_BUS_TIMEOUT_EN
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h40210040;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("tout_strobe", sys_ren_o, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("tout_wait_no_rsp", rsp_valid_o, 0);
    end
    tick();
    check("tout_rsp_valid", rsp_valid_o, 1);
    check("tout_flags", {rsp_tout_o, rsp_err_o}, 2'b11);
    check("tout_rdata", rsp_rdata_o, 0);
    man_ack = 1'b1; man_rdata = 32'h99999999;
    tick();
    man_ack = 1'b0;
    check("late_ack_ignored", {rsp_valid_o, rsp_tout_o, rsp_err_o}, 3'b111);
    check("late_ack_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    run_vec(vecs[1]);
`endif

    // Reset while the engine waits for an ack.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h40210030;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("rst_wait_strobe", sys_ren_o, 1);
    tick();
    check("rst_wait_busy", busy_o, 1);
    dac_rst_i = 1'b1;
    #1;
    check("midrst_strobes", {sys_wen_o, sys_ren_o}, 0);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_cmd_ready", cmd_ready_o, 1);
    check("midrst_busy", busy_o, 0);
    tick();
    dac_rst_i = 1'b0;
    man_ack = 1'b1; man_rdata = 32'h12121212;
    tick();
    man_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("postrst_no_rsp", rsp_valid_o, 0);
      check("postrst_no_strobe", {sys_wen_o, sys_ren_o}, 0);
      tick();
    end

    check("wen_ren_exclusive", 32'(both_hi), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
